// File: rtl/sm_rom_loader_pkg.sv
// sm_rom_loader_pkg
//   Shared constants for the program loader byte stream.
//   Stream layout: LEN_W-bit word count (low byte first), then that many
//   32-bit words, each sent least-significant byte first.
package sm_rom_loader_pkg;

    localparam int LEN_W  = 16;  // width of the word-count field
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // Little-endian join of the two length bytes.
    function automatic logic [LEN_W-1:0] len_join(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/sm_byte2word.sv
// sm_byte2word
//   Collects four stream bytes into one little-endian 32-bit word.
//   The word is presented combinationally together with the 4th byte so the
//   parent can register the memory write in the same clock edge.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   clr        drop any partial word (byte index back to 0)
//   byte_en    byte_in is accepted this cycle
//   byte_in    stream byte
//   word_out   {byte_in, b2, b1, b0}; meaningful when word_vld=1
//   word_vld   pulse: this cycle's byte completes a word
import sm_rom_loader_pkg::*;

module sm_byte2word (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_vld
);

    logic [1:0]        idx;
    logic [BYTE_W-1:0] b0, b1, b2;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            b0  <= '0;
            b1  <= '0;
            b2  <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (byte_en) begin
            idx <= idx + 2'd1;  // wraps 3 -> 0
            case (idx)
                2'd0:    b0 <= byte_in;
                2'd1:    b1 <= byte_in;
                2'd2:    b2 <= byte_in;
                default: ;      // 4th byte is forwarded directly
            endcase
        end
    end

    assign word_vld = byte_en && !clr && (idx == 2'd3);
    assign word_out = {byte_in, b2, b1, b0};

endmodule

// File: rtl/sm_rom_loader.sv
// sm_rom_loader
//   Fills instruction memory from a byte stream (e.g. UART RX) and holds the
//   CPU in reset while a load runs.
// Parameters
//   SIZE     instruction memory depth in 32-bit words (at most 65535)
//   TIMEOUT  max idle cycles between bytes during a load; 0 disables
// Ports
//   clk, rst             clock, synchronous active-high reset
//   start                pulse, arms a load when idle
//   in_valid/in_data     byte stream; consumed when in_valid && in_ready
//   in_ready             loader accepts a byte (depends on state only)
//   mem_we/addr/wd       instruction RAM write port, one cycle per word
//   cpu_rst              CPU reset request
//   busy                 load in progress (includes the done cycle)
//   done                 one-cycle pulse at end of a successful load
//   err                  sticky: oversize length or timeout; cleared by start
import sm_rom_loader_pkg::*;

module sm_rom_loader #(
    parameter int SIZE    = 64,
    parameter int TIMEOUT = 1000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [BYTE_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             mem_we,
    output logic [((SIZE>1)?$clog2(SIZE):1)-1:0] mem_addr,
    output logic [WORD_W-1:0]                mem_wd,
    output logic                             cpu_rst,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [LEN_W-1:0] SIZE_L = LEN_W'(SIZE);
    // Timeout fires on the TIMEOUT-th consecutive idle cycle.
    localparam logic [TW-1:0]    TLIM   = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [BYTE_W-1:0] len_lo;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  wcnt;
    logic [TW-1:0]     tcnt;
    logic              rst_hold;   // keeps cpu_rst high for one cycle after reset

    logic              loading, hs, tmo;
    logic [LEN_W-1:0]  len_next;
    logic [WORD_W-1:0] word;
    logic              word_vld;

    assign loading  = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
    assign in_ready = loading;
    assign hs       = in_valid && in_ready;
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign cpu_rst  = rst_hold || busy;
    assign len_next = len_join(in_data, len_lo);
    assign tmo      = (TIMEOUT != 0) && loading && !hs && (tcnt == TLIM);

    // Index is held clear outside DATA so every load, and every load cut
    // short by a timeout, starts on a word boundary.
    sm_byte2word u_b2w (
        .clk      (clk),
        .rst      (rst),
        .clr      (state != S_DATA),
        .byte_en  (hs && (state == S_DATA)),
        .byte_in  (in_data),
        .word_out (word),
        .word_vld (word_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_lo   <= '0;
            len      <= '0;
            wcnt     <= '0;
            tcnt     <= '0;
            rst_hold <= 1'b1;
            err      <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            rst_hold <= 1'b0;
            mem_we   <= 1'b0;

            // Every state change out of LEN0/LEN1/DATA coincides with a
            // handshake or a timeout, so this also covers "clear on entry".
            if (!loading || hs || tmo) tcnt <= '0;
            else                       tcnt <= tcnt + TW'(1);

            case (state)
                S_IDLE: if (start) begin
                    state <= S_LEN0;
                    err   <= 1'b0;
                    wcnt  <= '0;
                end
                S_LEN0: if (hs) begin
                    len_lo <= in_data;
                    state  <= S_LEN1;
                end
                S_LEN1: if (hs) begin
                    len <= len_next;
                    if (len_next == '0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_DATA;
                        // Oversize loads still drain the stream; excess
                        // words are simply not written.
                        if (len_next > SIZE_L) err <= 1'b1;
                    end
                end
                S_DATA: if (word_vld) begin
                    if (wcnt < SIZE_L) begin
                        mem_we   <= 1'b1;
                        mem_addr <= wcnt[AW-1:0];
                        mem_wd   <= word;
                    end
                    wcnt <= wcnt + LEN_W'(1);
                    if (wcnt + LEN_W'(1) == len) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (tmo) begin
                err   <= 1'b1;
                state <= S_IDLE;
            end
        end
    end

endmodule
